// File: rtl/freq_meter_pkg.sv
// Shared constants and FSM encoding for the gated edge-counting frequency meter.
package freq_meter_pkg;

  localparam int FM_GATE_CYCLES = 50_000;
  localparam int FM_CNT_W       = 16;
  localparam int FM_GATE_W      = 26;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_GATE = 2'd1,
    ST_DONE = 2'd2
  } fm_state_e;

endpackage

// File: rtl/freq_meter_sync_rise.sv
// Per-lane 2-flop synchronizer plus registered rising-edge detector.
// The pulse is one clk wide and appears 3 clk after the asynchronous rise.
module sync_rise #(
  parameter int NUM_LANES = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NUM_LANES-1:0] sig_in,
  output logic [NUM_LANES-1:0] rise
);

  logic [NUM_LANES-1:0] meta_q;
  logic [NUM_LANES-1:0] sync_q;
  logic [NUM_LANES-1:0] prev_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= '0;
      sync_q <= '0;
      prev_q <= '0;
      rise   <= '0;
    end else begin
      meta_q <= sig_in;
      sync_q <= meta_q;
      prev_q <= sync_q;
      rise   <= sync_q & ~prev_q;
    end
  end

endmodule

// File: rtl/freq_meter.sv
// Gated frequency meter: counts synchronized sig_in rising edges over a fixed
// window of GATE_CYCLES clocks and publishes the saturated count on done.
module freq_meter
  import freq_meter_pkg::*;
#(
  parameter int GATE_CYCLES = FM_GATE_CYCLES,
  parameter int CNT_W       = FM_CNT_W,
  parameter int GATE_W      = FM_GATE_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             sig_in,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] edge_cnt,
  output logic             overflow,
  output logic             no_signal
);

  localparam logic [GATE_W-1:0] LAST_TICK = GATE_W'(GATE_CYCLES - 1);
  localparam logic [CNT_W-1:0]  CNT_MAX   = '1;

  fm_state_e         state_q, state_d;
  logic [GATE_W-1:0] timer_q, timer_d;
  logic [CNT_W-1:0]  work_q, work_d;
  logic              wovf_q, wovf_d;
  logic              load;
  logic              edge_pulse;

  sync_rise #(.NUM_LANES(1)) u_sync (
    .clk    (clk),
    .rst_n  (rst_n),
    .sig_in (sig_in),
    .rise   (edge_pulse)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      timer_q <= '0;
      work_q  <= '0;
      wovf_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      work_q  <= work_d;
      wovf_q  <= wovf_d;
    end
  end

  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    work_d  = work_q;
    wovf_d  = wovf_q;
    load    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        timer_d = '0;
        work_d  = '0;
        wovf_d  = 1'b0;
        if (start) state_d = ST_GATE;
      end
      ST_GATE: begin
        timer_d = timer_q + GATE_W'(1);
        if (edge_pulse) begin
          if (work_q == CNT_MAX) wovf_d = 1'b1;
          else                   work_d = work_q + CNT_W'(1);
        end
        // Results are loaded from the next-state values so an edge on the
        // last gate cycle is already included when done rises.
        if (timer_q == LAST_TICK) begin
          state_d = ST_DONE;
          load    = 1'b1;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      edge_cnt  <= '0;
      overflow  <= 1'b0;
      no_signal <= 1'b0;
    end else if (load) begin
      edge_cnt  <= work_d;
      overflow  <= wovf_d;
      no_signal <= (work_d == '0);
    end
  end

  assign busy = (state_q == ST_GATE);
  assign done = (state_q == ST_DONE);

endmodule

// File: tb/tb_freq_meter.sv
// Self-checking bench: two meters (8-bit and 5-bit counters) share stimulus and
// are compared every cycle against a cycle-indexed arithmetic model.
module tb_freq_meter;
  localparam int G    = 100;
  localparam int HMAX = 16384;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic sig_in = 1'b0;

  logic       busy8, done8, ovf8, nos8;
  logic [7:0] cnt8;
  logic       busy5, done5, ovf5, nos5;
  logic [4:0] cnt5;

  always #5 clk = ~clk;

  freq_meter #(.GATE_CYCLES(G), .CNT_W(8), .GATE_W(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .start(start), .sig_in(sig_in),
    .busy(busy8), .done(done8), .edge_cnt(cnt8), .overflow(ovf8), .no_signal(nos8)
  );

  freq_meter #(.GATE_CYCLES(G), .CNT_W(5), .GATE_W(8)) dut5 (
    .clk(clk), .rst_n(rst_n), .start(start), .sig_in(sig_in),
    .busy(busy5), .done(done5), .edge_cnt(cnt5), .overflow(ovf5), .no_signal(nos5)
  );

  int checks = 0;
  int errors = 0;

  function automatic void chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s at t=%0t: actual=%0d expected=%0d", nm, $time, act, exp);
    end
  endfunction

  // ---------------- behavioural model ----------------
  // Cycle n is the interval after the n-th posedge. A rise first sampled at
  // edge k produces a counted pulse in cycle k+2. A gate started by start
  // sampled at edge s covers cycles s..s+G-1 and done is cycle s+G.
  int cyc = 0;
  bit pulse_at [HMAX];
  bit prev_s = 1'b0;
  int gs = -1000;
  int total = 0;
  bit exp_busy = 1'b0, exp_done = 1'b0;
  int r_cnt8 = 0, r_cnt5 = 0;
  bit r_ovf8 = 1'b0, r_ovf5 = 1'b0, r_nos = 1'b0;

  initial forever begin
    @(posedge clk);
    cyc++;
    if (!rst_n) begin
      for (int k = 0; k < 3; k++) if (cyc + k < HMAX) pulse_at[cyc+k] = 1'b0;
      prev_s = 1'b0;
      gs = -1000;
      total = 0;
      exp_busy = 1'b0; exp_done = 1'b0;
      r_cnt8 = 0; r_cnt5 = 0; r_ovf8 = 1'b0; r_ovf5 = 1'b0; r_nos = 1'b0;
    end else begin
      if (exp_busy && cyc - 1 < HMAX && pulse_at[cyc-1]) total++;
      if (!exp_busy && !exp_done && start) begin
        gs = cyc;
        total = 0;
      end
      exp_busy = (cyc >= gs) && (cyc < gs + G);
      exp_done = (cyc == gs + G);
      if (exp_done) begin
        r_cnt8 = (total > 255) ? 255 : total;
        r_ovf8 = (total > 255);
        r_cnt5 = (total > 31) ? 31 : total;
        r_ovf5 = (total > 31);
        r_nos  = (total == 0);
      end
      if (sig_in && !prev_s && cyc + 2 < HMAX) pulse_at[cyc+2] = 1'b1;
      prev_s = sig_in;
    end
  end

  // ---------------- per-cycle compare ----------------
  int done_count = 0;
  int last_done_cyc = -1;
  int cap_cnt8 = 0, cap_cnt5 = 0;
  bit cap_ovf8 = 1'b0, cap_ovf5 = 1'b0, cap_nos = 1'b0;

  initial forever begin
    @(negedge clk);
    if (!rst_n) begin
      chk("rst_busy8", int'(busy8), 0); chk("rst_done8", int'(done8), 0);
      chk("rst_cnt8", int'(cnt8), 0);   chk("rst_ovf8", int'(ovf8), 0);
      chk("rst_nos8", int'(nos8), 0);
      chk("rst_busy5", int'(busy5), 0); chk("rst_cnt5", int'(cnt5), 0);
      chk("rst_ovf5", int'(ovf5), 0);
    end else begin
      chk("busy8", int'(busy8), int'(exp_busy)); chk("done8", int'(done8), int'(exp_done));
      chk("cnt8", int'(cnt8), r_cnt8);           chk("ovf8", int'(ovf8), int'(r_ovf8));
      chk("nos8", int'(nos8), int'(r_nos));
      chk("busy5", int'(busy5), int'(exp_busy)); chk("done5", int'(done5), int'(exp_done));
      chk("cnt5", int'(cnt5), r_cnt5);           chk("ovf5", int'(ovf5), int'(r_ovf5));
      chk("nos5", int'(nos5), int'(r_nos));
      if (done8) begin
        done_count++;
        last_done_cyc = cyc;
        cap_cnt8 = cnt8; cap_ovf8 = ovf8; cap_nos = nos8;
        cap_cnt5 = cnt5; cap_ovf5 = ovf5;
      end
    end
  end

  // ---------------- stimulus ----------------
  int per = 0;       // 0: manual level, 255: random bits, else square-wave period
  int ph = 0;
  bit man_sig = 1'b0;

  task automatic tick(input bit st);
    @(posedge clk); #1;
    if (per == 0)        sig_in = man_sig;
    else if (per == 255) sig_in = 1'($urandom_range(0, 1));
    else begin
      ph = (ph + 1) % per;
      sig_in = (ph < per / 2);
    end
    start = st;
  endtask

  task automatic wait_done(input int budget);
    int d0;
    d0 = done_count;
    for (int i = 0; i < budget; i++) begin
      tick(1'b0);
      if (done_count > d0) return;
    end
    chk("wait_done_timeout", 0, 1);
  endtask

  task automatic run_one(input int p, output int sc);
    per = p;
    repeat (8) tick(1'b0);
    tick(1'b1);
    sc = cyc;
    wait_done(G + 20);
  endtask

  initial begin
    int sc, d0;
    int rpos [4] = '{1, 0, 100, 101};
    int rexp [4] = '{1, 0, 1, 0};

    repeat (4) tick(1'b0);
    chk("reset_busy", int'(busy8), 0);
    chk("reset_cnt", int'(cnt8), 0);
    rst_n = 1'b1;
    repeat (3) tick(1'b0);

    // period 10 -> exactly 10 edges per 100-cycle gate, done 101 after start
    run_one(10, sc);
    chk("lat_p10", last_done_cyc - sc, 101);
    chk("cnt_p10", cap_cnt8, 10);
    chk("model_p10", r_cnt8, 10);
    chk("ovf_p10", int'(cap_ovf8), 0);
    chk("nos_p10", int'(cap_nos), 0);

    // no signal
    man_sig = 1'b0;
    run_one(0, sc);
    chk("cnt_low", cap_cnt8, 0);
    chk("nos_low", int'(cap_nos), 1);
    chk("ovf_low", int'(cap_ovf8), 0);

    // period 2 -> 50 edges; 5-bit meter saturates
    run_one(2, sc);
    chk("cnt8_p2", cap_cnt8, 50);
    chk("ovf8_p2", int'(cap_ovf8), 0);
    chk("cnt5_p2", cap_cnt5, 31);
    chk("ovf5_p2", int'(cap_ovf5), 1);
    chk("model5_p2", r_cnt5, 31);

    // extra starts mid-gate and in DONE are ignored; start right after DONE accepted
    per = 10;
    repeat (8) tick(1'b0);
    d0 = done_count;
    tick(1'b1);
    sc = cyc;
    for (int i = 1; i <= 102; i++) tick(i == 30 || i == 101 || i == 102);
    chk("single_done", done_count - d0, 1);
    chk("lat_extra", last_done_cyc - sc, 101);
    wait_done(G + 20);
    chk("lat_restart", last_done_cyc - sc, 203);
    chk("cnt_restart", cap_cnt8, 10);

    // reset mid-gate aborts with no done pulse
    repeat (5) tick(1'b0);
    tick(1'b1);
    repeat (50) tick(1'b0);
    chk("busy_before_rst", int'(busy8), 1);
    d0 = done_count;
    rst_n = 1'b0;
    #1;
    chk("busy_async_rst", int'(busy8), 0);
    chk("cnt_async_rst", int'(cnt8), 0);
    repeat (3) tick(1'b0);
    rst_n = 1'b1;
    repeat (120) tick(1'b0);
    chk("no_done_after_rst", done_count - d0, 0);
    run_one(10, sc);
    chk("cnt_after_rst", cap_cnt8, 10);

    // single edge at gate boundaries: first/last gate cycle counted, one outside not
    per = 0;
    for (int t = 0; t < 4; t++) begin
      man_sig = 1'b0;
      repeat (8) tick(1'b0);
      sc = cyc;
      for (int i = 0; i <= 105; i++) begin
        man_sig = (i >= rpos[t]);
        tick(i == 3);
      end
      chk("edge_boundary_lat", last_done_cyc - sc, 104 + 1);
      chk("edge_boundary_cnt", cap_cnt8, rexp[t]);
      man_sig = 1'b0;
    end

    // randomized traffic: random periods, noise, starts and resets
    for (int blk = 0; blk < 14; blk++) begin
      int mode;
      mode = $urandom_range(0, 3);
      man_sig = 1'($urandom_range(0, 1));
      per = (mode == 0) ? 0 : (mode == 1) ? 255 : $urandom_range(2, 24);
      for (int i = 0; i < 250; i++) begin
        if ($urandom_range(0, 599) == 0) begin
          start = 1'b0;
          rst_n = 1'b0;
          tick(1'b0);
          tick(1'b0);
          rst_n = 1'b1;
          tick(1'b0);
        end
        tick($urandom_range(0, 39) == 0);
      end
    end
    repeat (G + 5) tick(1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/freq_meter.md
FREQ_METER -- requirements
Module: freq_meter

Interface
REQ-001 Parameter GATE_CYCLES, default 50_000, gate window length in clk cycles (>=2).
REQ-002 Parameter CNT_W, default 16, width of edge_cnt.
REQ-003 Parameter GATE_W, default 26, width of the internal gate timer; SHALL hold GATE_CYCLES-1.
REQ-004 clk  input  1  system clock; all logic on posedge clk.
REQ-005 rst_n  input  1  reset, asynchronous, active-low.
REQ-006 start  input  1  one-cycle request to begin a measurement.
REQ-007 sig_in  input  1  asynchronous square wave under test, for example a divided clock.
REQ-008 busy  output  1  high while a measurement is in progress.
REQ-009 done  output  1  one-cycle pulse; result registers updated in this same cycle.
REQ-010 edge_cnt  output  CNT_W  rising edges counted in the last completed gate.
REQ-011 overflow  output  1  last gate saturated edge_cnt.
REQ-012 no_signal  output  1  last gate counted zero edges.

Function
REQ-013 sig_in SHALL pass through a 2-flop synchronizer, then a registered rising-edge detector; edge pulse is 1 clk wide, 3 clk after the sig_in rise.
REQ-014 FSM states: IDLE, GATE, DONE.
REQ-015 IDLE: busy=0; start=1 -> GATE next cycle; gate timer and working counter cleared to 0.
REQ-016 GATE: busy=1; gate timer increments each cycle; occupancy exactly GATE_CYCLES cycles; at timer==GATE_CYCLES-1 -> DONE.
REQ-017 Edge pulses arriving on any GATE cycle, including the first and the last, SHALL be counted; pulses in IDLE/DONE SHALL be ignored.
REQ-018 Working counter SHALL saturate at 2^CNT_W-1, never wrap; any edge arriving at saturation sets the working overflow bit.
REQ-019 DONE: lasts one cycle; done=1, busy=0; edge_cnt, overflow, no_signal loaded from the working values; next state IDLE.
REQ-020 start during GATE or DONE SHALL be ignored, with no queuing. start in IDLE one cycle after DONE is accepted.
REQ-021 Result outputs SHALL hold between done pulses and SHALL NOT change during GATE.
REQ-022 Latency: start sampled at cycle T -> done at cycle T+1+GATE_CYCLES.

Reset
REQ-023 rst_n low SHALL asynchronously force IDLE, busy=0, done=0, edge_cnt=0, overflow=0, no_signal=0, timers/counters=0, and synchronizer/edge flops=0.
REQ-024 Reset mid-GATE SHALL abort the measurement with no done pulse; the first rising edge on sig_in after reset release counts only if it occurs within a later GATE.

Structure
REQ-025 Shared package: FSM state encoding and the default GATE_CYCLES/CNT_W constants.
REQ-026 One sub-module, sync_rise, containing the 2-flop synchronizer and rising-edge detector; it is reused by other blocks that consume divided clocks.

Verification (GATE_CYCLES=100, CNT_W=8)
REQ-027 sig_in period 10 clk, start pulse -> done exactly 101 clk after start; edge_cnt=10, overflow=0, no_signal=0.
REQ-028 sig_in held low, start -> edge_cnt=0, no_signal=1, overflow=0.
REQ-029 sig_in period 2 clk with CNT_W=5 -> edge_cnt=31, overflow=1.
REQ-030 Extra start pulses mid-GATE and in the DONE cycle -> single done pulse; timing unchanged from the first start.
REQ-031 rst_n low at gate cycle 50 -> busy=0 immediately, no done pulse, outputs 0; a new start after release gives a correct count.
REQ-032 sig_in rise placed so its edge pulse lands on gate cycle 0, then on gate cycle 99 -> each edge is counted once, giving a count equal to the expected value +1 versus the shifted placement.
